// File: rtl/instr_fetch.sv
// Instruction fetch stage: two-state fill/run fetcher for a registered
// instruction memory, with a static backward-branch / JAL predictor.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        l_pause,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    output logic        imem_renable,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        if_valid,
    output logic        if_pred_taken,
    output logic [31:0] if_pred_target
);

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;
    localparam logic [31:0] RESET_ADDR = RESET_PC & ALIGN_MASK;

    state_e      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] resp_pc_q, resp_pc_d;

    logic [6:0]  opcode;
    logic [31:0] imm_j;
    logic [31:0] imm_b;
    logic [31:0] imm;
    logic        predict;

    assign imem_addr    = fetch_pc_q;
    assign imem_renable = resetn;
    assign if_instr     = imem_rdata;
    assign if_pc        = resp_pc_q;
    assign if_valid     = (state_q == RUN) && !redirect_valid;

    // Static predictor: JAL always taken, conditional branch taken if backward.
    always_comb begin
        opcode  = imem_rdata[6:0];
        imm_j   = {{12{imem_rdata[31]}}, imem_rdata[19:12],
                   imem_rdata[20], imem_rdata[30:21], 1'b0};
        imm_b   = {{20{imem_rdata[31]}}, imem_rdata[7],
                   imem_rdata[30:25], imem_rdata[11:8], 1'b0};
        predict = 1'b0;
        imm     = imm_b;
        case (opcode)
            7'b1101111: begin
                predict = 1'b1;
                imm     = imm_j;
            end
            7'b1100011: begin
                predict = imem_rdata[31];
                imm     = imm_b;
            end
            default: begin
                predict = 1'b0;
                imm     = imm_b;
            end
        endcase
        if_pred_target = resp_pc_q + imm;
        if_pred_taken  = predict && (state_q == RUN);
    end

    // Next-state selection: redirect beats stall beats normal sequencing.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        state_d    = state_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc & ALIGN_MASK;
            state_d    = FILL;
        end else if (!l_pause) begin
            if (state_q == FILL) begin
                resp_pc_d  = fetch_pc_q;
                fetch_pc_d = fetch_pc_q + 32'd4;
                state_d    = RUN;
            end else if (if_pred_taken) begin
                // The sequential word arriving next cycle is dropped by FILL.
                fetch_pc_d = if_pred_target & ALIGN_MASK;
                state_d    = FILL;
            end else begin
                resp_pc_d  = fetch_pc_q;
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
        end
    end

    // State registers; asynchronous reset abandons any in-flight fetch.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fetch_pc_q <= RESET_ADDR;
            resp_pc_q  <= RESET_ADDR;
            state_q    <= FILL;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            state_q    <= state_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: cycle table with scoreboard queue,
// plus hand-written reset sequences.
module tb_instr_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] JAL = 32'hFF9F_F06F;
    localparam logic [31:0] BEQ = 32'h0000_0863;
    localparam logic [31:0] BNE = 32'hFE00_1EE3;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        l_pause = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] imem_addr;
    logic        imem_renable;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_valid;
    logic        if_pred_taken;
    logic [31:0] if_pred_target;

    int n_chk = 0;
    int n_fail = 0;

    instr_fetch dut (
        .clk            (clk),
        .resetn         (resetn),
        .l_pause        (l_pause),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_renable   (imem_renable),
        .imem_rdata     (imem_rdata),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .if_valid       (if_valid),
        .if_pred_taken  (if_pred_taken),
        .if_pred_target (if_pred_target)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [logic [31:0]];

    function automatic logic [31:0] rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return NOP;
    endfunction

    // Registered memory that holds its output while paused.
    always @(posedge clk)
        if (imem_renable && !l_pause)
            imem_rdata <= rd(imem_addr);

    typedef struct {
        logic        pause;
        logic        rv;
        logic [31:0] rpc;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] ei;
        logic        ept;
        logic [31:0] etgt;
        logic        ca;
        logic [31:0] ea;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    function automatic vec_t mk(
        input logic pause, input logic rv, input logic [31:0] rpc,
        input logic ev, input logic [31:0] epc, input logic [31:0] ei,
        input logic ept, input logic [31:0] etgt,
        input logic ca, input logic [31:0] ea);
        vec_t v;
        v.pause = pause; v.rv = rv; v.rpc = rpc;
        v.ev = ev; v.epc = epc; v.ei = ei;
        v.ept = ept; v.etgt = etgt; v.ca = ca; v.ea = ea;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic chk_vec(input int row, input vec_t e);
        string s;
        s = $sformatf("row%0d", row);
        chk({s, " if_valid"}, {31'b0, if_valid}, {31'b0, e.ev});
        chk({s, " pred_taken"}, {31'b0, if_pred_taken}, {31'b0, e.ept});
        if (e.ev) begin
            chk({s, " if_pc"}, if_pc, e.epc);
            chk({s, " if_instr"}, if_instr, e.ei);
        end
        if (e.ept)
            chk({s, " pred_target"}, if_pred_target, e.etgt);
        if (e.ca)
            chk({s, " imem_addr"}, imem_addr, e.ea);
    endtask

    initial begin
        mem[32'h10] = JAL;
        mem[32'h20] = BEQ;
        mem[32'h30] = BNE;

        // pause, rv, rpc, ev, epc, ei, ept, etgt, ca, ea
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0));
        tbl.push_back(mk(0, 0, 0, 1, 32'h00, NOP, 0, 0, 1, 32'h4));
        tbl.push_back(mk(0, 0, 0, 1, 32'h04, NOP, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 32'h08, NOP, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 32'h0C, NOP, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 32'h10, JAL, 1, 32'h08, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h08));
        tbl.push_back(mk(0, 0, 0, 1, 32'h08, NOP, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 32'h0C, NOP, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 32'h20, 0, 0, 0, 1, 32'h08, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h20));
        tbl.push_back(mk(0, 0, 0, 1, 32'h20, BEQ, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 32'h24, NOP, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 32'h28, NOP, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 32'h2C, NOP, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 32'h30, BNE, 1, 32'h2C, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h2C));
        tbl.push_back(mk(0, 0, 0, 1, 32'h2C, NOP, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 32'h40, 0, 0, 0, 1, 32'h2C, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h40));
        tbl.push_back(mk(1, 0, 0, 1, 32'h40, NOP, 0, 0, 1, 32'h44));
        tbl.push_back(mk(1, 0, 0, 1, 32'h40, NOP, 0, 0, 1, 32'h44));
        tbl.push_back(mk(1, 0, 0, 1, 32'h40, NOP, 0, 0, 1, 32'h44));
        tbl.push_back(mk(0, 0, 0, 1, 32'h40, NOP, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 32'h103, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h100));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h100));
        tbl.push_back(mk(0, 1, 32'hFFFF_FFF8, 1'b0, 32'h100, NOP, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFF8));
        tbl.push_back(mk(0, 0, 0, 1, 32'hFFFF_FFF8, NOP, 0, 0, 1, 32'hFFFF_FFFC));
        tbl.push_back(mk(0, 0, 0, 1, 32'hFFFF_FFFC, NOP, 0, 0, 1, 32'h0));
        tbl.push_back(mk(0, 0, 0, 1, 32'h00, NOP, 0, 0, 1, 32'h4));

        // Reset state.
        repeat (3) @(negedge clk);
        #3;
        chk("rst if_valid", {31'b0, if_valid}, 32'h0);
        chk("rst renable", {31'b0, imem_renable}, 32'h0);
        chk("rst imem_addr", imem_addr, 32'h0);
        chk("rst pred_taken", {31'b0, if_pred_taken}, 32'h0);

        @(negedge clk);
        resetn = 1'b1;
        foreach (tbl[i]) begin
            if (i != 0) @(negedge clk);
            l_pause        = tbl[i].pause;
            redirect_valid = tbl[i].rv;
            redirect_pc    = tbl[i].rpc;
            sb.push_back(tbl[i]);
            #3;
            if (i == 0)
                chk("renable after release", {31'b0, imem_renable}, 32'h1);
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL scoreboard empty at row %0d", i);
            end else begin
                chk_vec(i, sb.pop_front());
            end
        end

        // Asynchronous reset in the middle of a fetch stream.
        @(negedge clk);
        l_pause = 1'b0;
        redirect_valid = 1'b0;
        #2;
        chk("pre-reset if_valid", {31'b0, if_valid}, 32'h1);
        chk("pre-reset imem_addr", imem_addr, 32'h8);
        resetn = 1'b0;
        #1;
        chk("async rst if_valid", {31'b0, if_valid}, 32'h0);
        chk("async rst imem_addr", imem_addr, 32'h0);
        chk("async rst renable", {31'b0, imem_renable}, 32'h0);
        chk("async rst pred_taken", {31'b0, if_pred_taken}, 32'h0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        #3;
        chk("rerelease cyc1 valid", {31'b0, if_valid}, 32'h0);
        @(negedge clk);
        #3;
        chk("rerelease cyc2 valid", {31'b0, if_valid}, 32'h1);
        chk("rerelease cyc2 pc", if_pc, 32'h0);
        chk("rerelease cyc2 instr", if_instr, NOP);
        @(negedge clk);
        #3;
        chk("rerelease cyc3 pc", if_pc, 32'h4);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
